// File: rtl/bit_mismatch_scoreboard.sv
// Clocked scoreboard for a 1-bit DUT/reference pair: counts accepted samples
// and mismatches, latches the first mismatch index and a pass/fail verdict.
module bit_mismatch_scoreboard #(
  parameter int unsigned CNT_W         = 16,
  parameter bit          STOP_ON_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             dut_bit,
  input  logic             ref_bit,
  input  logic             in_last,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_vld,
  output logic             cnt_sat
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
  logic             first_err_vld_q, first_err_vld_d;
  logic             cnt_sat_q, cnt_sat_d;
  logic             accept;
  logic             mismatch;

  // start takes priority, so a sample presented alongside it is dropped
  assign accept   = (state_q == RUN) && in_valid && !start;
  assign mismatch = accept && (dut_bit != ref_bit);

  always_comb begin
    state_d         = state_q;
    sample_cnt_d    = sample_cnt_q;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    first_err_vld_d = first_err_vld_q;
    if (start) begin
      state_d         = RUN;
      sample_cnt_d    = '0;
      err_cnt_d       = '0;
      first_err_idx_d = '0;
      first_err_vld_d = 1'b0;
    end else if (accept) begin
      if (sample_cnt_q != CNT_MAX) sample_cnt_d = sample_cnt_q + 1'b1;
      if (mismatch) begin
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
        if (!first_err_vld_q) begin
          first_err_idx_d = sample_cnt_q;
          first_err_vld_d = 1'b1;
        end
      end
      if (in_last || (STOP_ON_FIRST && mismatch)) state_d = DONE;
    end
    // Sticky flag tracks the next counter values so it rises with the counter
    cnt_sat_d = (cnt_sat_q && !start) || (&sample_cnt_d) || (&err_cnt_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      sample_cnt_q    <= '0;
      err_cnt_q       <= '0;
      first_err_idx_q <= '0;
      first_err_vld_q <= 1'b0;
      cnt_sat_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      sample_cnt_q    <= sample_cnt_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_vld_q <= first_err_vld_d;
      cnt_sat_q       <= cnt_sat_d;
    end
  end

  assign in_ready      = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign pass          = (state_q == DONE) && (err_cnt_q == '0);
  assign sample_cnt    = sample_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_vld = first_err_vld_q;
  assign cnt_sat       = cnt_sat_q;

endmodule

// File: tb/tb_bit_mismatch_scoreboard.sv
// Bench for bit_mismatch_scoreboard: three instances (run-to-last, stop-on-first,
// 3-bit counters) share the sample bus; each is started by its own start bit.
module tb_bit_mismatch_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] starts;
  logic       in_valid, dut_bit, ref_bit, in_last;

  logic        rdy_a, dn_a, ps_a, fv_a, sat_a;
  logic [15:0] sc_a, ec_a, fi_a;
  logic        rdy_b, dn_b, ps_b, fv_b, sat_b;
  logic [15:0] sc_b, ec_b, fi_b;
  logic        rdy_c, dn_c, ps_c, fv_c, sat_c;
  logic [2:0]  sc_c, ec_c, fi_c;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  // Model: unbounded counts per instance, saturation applied when comparing
  int m_n[3], m_e[3], m_first[3];
  bit m_run[3], m_done[3];

  always #5 clk = ~clk;

  bit_mismatch_scoreboard #(.CNT_W(16), .STOP_ON_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(starts[0]), .in_valid(in_valid), .in_ready(rdy_a),
    .dut_bit(dut_bit), .ref_bit(ref_bit), .in_last(in_last), .done(dn_a), .pass(ps_a),
    .sample_cnt(sc_a), .err_cnt(ec_a), .first_err_idx(fi_a), .first_err_vld(fv_a),
    .cnt_sat(sat_a));

  bit_mismatch_scoreboard #(.CNT_W(16), .STOP_ON_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(starts[1]), .in_valid(in_valid), .in_ready(rdy_b),
    .dut_bit(dut_bit), .ref_bit(ref_bit), .in_last(in_last), .done(dn_b), .pass(ps_b),
    .sample_cnt(sc_b), .err_cnt(ec_b), .first_err_idx(fi_b), .first_err_vld(fv_b),
    .cnt_sat(sat_b));

  bit_mismatch_scoreboard #(.CNT_W(3), .STOP_ON_FIRST(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(starts[2]), .in_valid(in_valid), .in_ready(rdy_c),
    .dut_bit(dut_bit), .ref_bit(ref_bit), .in_last(in_last), .done(dn_c), .pass(ps_c),
    .sample_cnt(sc_c), .err_cnt(ec_c), .first_err_idx(fi_c), .first_err_vld(fv_c),
    .cnt_sat(sat_c));

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_n[k] = 0; m_e[k] = 0; m_first[k] = -1; m_run[k] = 1'b0; m_done[k] = 1'b0;
      end else if (starts[k]) begin
        m_n[k] = 0; m_e[k] = 0; m_first[k] = -1; m_run[k] = 1'b1; m_done[k] = 1'b0;
      end else if (m_run[k] && in_valid) begin
        if (dut_bit != ref_bit) begin
          if (m_first[k] < 0) m_first[k] = m_n[k];
          m_e[k]++;
        end
        m_n[k]++;
        if (in_last || (k == 1 && dut_bit != ref_bit)) begin
          m_run[k] = 1'b0; m_done[k] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int sat_at(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic cmp(input int k, input int rdy, input int dn, input int ps, input int sc,
                     input int ec, input int fi, input int fv, input int sat);
    int mx;
    mx = (k == 2) ? 7 : 65535;
    chk($sformatf("i%0d in_ready", k), rdy, int'(m_run[k]));
    chk($sformatf("i%0d done", k), dn, int'(m_done[k]));
    chk($sformatf("i%0d pass", k), ps, int'(m_done[k] && m_e[k] == 0));
    chk($sformatf("i%0d sample_cnt", k), sc, sat_at(m_n[k], mx));
    chk($sformatf("i%0d err_cnt", k), ec, sat_at(m_e[k], mx));
    chk($sformatf("i%0d first_err_idx", k), fi, (m_first[k] < 0) ? 0 : sat_at(m_first[k], mx));
    chk($sformatf("i%0d first_err_vld", k), fv, int'(m_first[k] >= 0));
    chk($sformatf("i%0d cnt_sat", k), sat, int'(m_n[k] >= mx || m_e[k] >= mx));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp(0, rdy_a, dn_a, ps_a, sc_a, ec_a, fi_a, fv_a, sat_a);
      cmp(1, rdy_b, dn_b, ps_b, sc_b, ec_b, fi_b, fv_b, sat_b);
      cmp(2, rdy_c, dn_c, ps_c, sc_c, ec_c, fi_c, fv_c, sat_c);
    end
  end

  task automatic cyc(input logic [2:0] st, input logic v, input logic d, input logic r,
                     input logic l);
    starts = st; in_valid = v; dut_bit = d; ref_bit = r; in_last = l;
    @(posedge clk);
    #1;
    starts = '0; in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    logic a, b, x;
    rst_n = 1'b0; starts = '0; in_valid = 1'b0; dut_bit = 1'b0; ref_bit = 1'b0;
    in_last = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("reset in_ready", rdy_a, 0);
    chk("reset done", dn_a, 0);
    chk("reset sample_cnt", sc_a, 0);

    // Clean stream of 11 samples
    cyc(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      a = 1'($urandom); b = 1'($urandom); x = a & b;
      cyc(3'b000, 1'b1, x, x, i == 10);
    end
    chk("t1 sample_cnt", sc_a, 11);
    chk("t1 err_cnt", ec_a, 0);
    chk("t1 done", dn_a, 1);
    chk("t1 pass", ps_a, 1);
    chk("t1 first_err_vld", fv_a, 0);

    // Restart with a mismatching last sample alongside start: must be dropped
    cyc(3'b001, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t2 start drops sample", sc_a, 0);
    for (int i = 0; i < 11; i++) begin
      a = 1'($urandom); b = 1'($urandom); x = a & b;
      cyc(3'b000, 1'b1, x ^ (i == 3 || i == 7), x, i == 10);
    end
    chk("t2 sample_cnt", sc_a, 11);
    chk("t2 err_cnt", ec_a, 2);
    chk("t2 first_err_idx", fi_a, 3);
    chk("t2 first_err_vld", fv_a, 1);
    chk("t2 pass", ps_a, 0);

    // Stop on first mismatch at index 4
    cyc(3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(3'b000, 1'b1, i == 4, 1'b0, 1'b0);
      if (i == 4) chk("t3 done after stop", dn_b, 1);
    end
    chk("t3 sample_cnt", sc_b, 5);
    chk("t3 err_cnt", ec_b, 1);
    chk("t3 in_ready", rdy_b, 0);
    chk("t3 first_err_idx", fi_b, 4);

    // Gapped valid with in_last on idle cycles
    cyc(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(3'b000, 1'b1, 1'b0, 1'b0, i == 5);
      if (i < 5) cyc(3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
      if (i == 2) chk("t4 no exit on idle last", dn_a, 0);
    end
    chk("t4 sample_cnt", sc_a, 6);
    chk("t4 done", dn_a, 1);
    chk("t4 pass", ps_a, 1);

    // 3-bit counters saturate
    cyc(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(3'b000, 1'b1, 1'b1, 1'b0, i == 9);
    chk("t5 sample_cnt", sc_c, 7);
    chk("t5 err_cnt", ec_c, 7);
    chk("t5 cnt_sat", sat_c, 1);
    chk("t5 first_err_idx", fi_c, 0);
    cyc(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5 restart sample_cnt", sc_c, 0);
    chk("t5 restart err_cnt", ec_c, 0);
    chk("t5 restart cnt_sat", sat_c, 0);
    chk("t5 restart in_ready", rdy_c, 1);

    // Asynchronous reset mid-run
    cyc(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(3'b000, 1'b1, i == 1, 1'b0, 1'b0);
    chk("t6 pre-reset sample_cnt", sc_a, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async sample_cnt", sc_a, 0);
    chk("t6 async err_cnt", ec_a, 0);
    chk("t6 async first_err_vld", fv_a, 0);
    chk("t6 async in_ready", rdy_a, 0);
    chk("t6 async cnt_sat c", sat_c, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6 post sample_cnt", sc_a, 0);
    chk("t6 post in_ready", rdy_a, 0);
    chk("t6 post done", dn_a, 0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
